ov7670_init_sequencer: RTL
==========================

# ov7670_init_sequencer

Power-up and register-load sequencer for the OV7670 camera. It drives the camera power-down and reset pins through a timed power-on sequence. It then walks a synchronous command ROM and feeds each 16-bit entry to the shared `i2c_sender` through its send/taken handshake. The block sits between the command ROM and `i2c_sender` inside the camera control path, and replaces ad-hoc free-running sequencing with a defined, restartable state machine.

## Interface
- `CLKS_PER_MS`, 50000: `clk` cycles per millisecond tick.
- `PWR_WAIT_MS`, 1: time held in power-down after start.
- `RST_PULSE_MS`, 1: time `cam_reset_n` is held low with power up.
- `RST_WAIT_MS`, 10: settle time after reset release before the first write.
- `ROM_AW`, 8: command ROM address width.
- `AUTO_START`, 1: 1 starts the sequence on the first cycle after `rst` deasserts.

Ports:
- `clk` in 1: system clock.
- `rst` in 1: synchronous, active-high reset.
- `resend` in 1: single-cycle pulse that restarts the full sequence.
- `rom_addr` out ROM_AW: command ROM address.
- `rom_data` in 16: ROM entry, `[15:8]` register, `[7:0]` value. Valid one cycle after `rom_addr` changes.
- `i2c_send` out 1: write request to `i2c_sender`.
- `i2c_register` out 8: register byte; stable while `i2c_send` is high.
- `i2c_value` out 8: value byte; stable while `i2c_send` is high.
- `i2c_taken` in 1: one-cycle pulse from `i2c_sender` indicating the current write was accepted.
- `cam_pwdn` out 1: camera power-down pin, 1 = powered down.
- `cam_reset_n` out 1: camera reset pin, 0 = reset.
- `busy` out 1: high in every state except IDLE and DONE.
- `config_finished` out 1: high in DONE.
- `rom_overflow` out 1: sticky; set when the ROM address space is exhausted without an end marker.

## Operation
States: IDLE, PWR_WAIT, RST_PULSE, RST_WAIT, FETCH, DECODE, SEND, DELAY, DONE.

- **IDLE**: `cam_pwdn`=1, `cam_reset_n`=0. Exit to PWR_WAIT on `resend`, or on the first post-reset cycle if AUTO_START=1.
- **PWR_WAIT**: `cam_pwdn`=1, `cam_reset_n`=0 for PWR_WAIT_MS ms.
- **RST_PULSE**: `cam_pwdn`=0, `cam_reset_n`=0 for RST_PULSE_MS ms.
- **RST_WAIT**: `cam_pwdn`=0, `cam_reset_n`=1 for RST_WAIT_MS ms. Then `rom_addr`←0 and go to FETCH.
- **FETCH**: one wait cycle for ROM latency, then DECODE.
- **DECODE**: classify `rom_data`.
  - 16'hFFFF: go to DONE.
  - 16'hF0nn with the macro compiled in: go to DELAY with nn ms. nn=0 is treated as a no-op and advances.
  - Anything else: latch the register and value bytes, then go to SEND.
- **SEND**: `i2c_send`=1 until the cycle `i2c_taken`=1. On that cycle:
  - `i2c_send` drops on the next cycle.
  - If `rom_addr` = 2^ROM_AW−1: set `rom_overflow` and go to DONE.
  - Otherwise `rom_addr`+1, then FETCH.
- **DELAY**: count nn ms, then advance exactly as after a taken write, including the overflow check.
- **DONE**: `config_finished`=1, `cam_pwdn`=0, `cam_reset_n`=1. `resend` goes to PWR_WAIT and clears `rom_overflow`.

General rules:
- `resend` is ignored while `busy`=1. The bench must never see a write truncated by a restart.
- The millisecond timer is a prescaler of width clog2(CLKS_PER_MS) plus an 8-bit ms counter. Both clear on every state entry.
- A state with a 0 ms parameter lasts exactly 1 cycle.
- `i2c_taken` outside SEND is ignored.

## Timing
- Reset values: state IDLE; `rom_addr`=0; `i2c_send`=0; `i2c_register`=0; `i2c_value`=0; `cam_pwdn`=1; `cam_reset_n`=0; `busy`=0; `config_finished`=0; `rom_overflow`=0.
- `rst` mid-sequence, including mid-SEND, returns to the reset values on the next edge. `i2c_send` drops immediately.
- All outputs are registered.
- ROM entry N to `i2c_send` rising takes 2 cycles: FETCH, then DECODE.
- `i2c_taken` to the next `i2c_send` rising takes 3 cycles: advance, FETCH, DECODE.
- Timed states last exactly N·CLKS_PER_MS cycles, ±0.

## Configuration
- **`OV7670_DELAY_CMD_EN`**
  - Defined: ROM entries 16'hF0nn are pseudo-commands. They insert an nn ms pause and are never sent to the camera.
  - Undefined: 16'hF0nn is sent as an ordinary write to register 0xF0. The DELAY state and its counter are not compiled.
  - The 16'hFFFF end marker is honoured in both cases.

## Test plan
- **Reset values**: assert `rst` for 3 cycles, then release with AUTO_START=0 and no `resend` → all outputs hold their reset values for 100 cycles.
- **Power-on timing**: CLKS_PER_MS=4, default ms parameters, AUTO_START=1 → `cam_pwdn` falls at cycle 4, `cam_reset_n` rises at cycle 8, first `i2c_send` at cycle 8+40+2.
- **Write sequence**: ROM {12'h..: 0x1280, 0x1101, 0xFFFF}; taken returned 5 cycles after each send → two writes with `i2c_register`/`i2c_value` = 0x12/0x80 and 0x11/0x01, then `config_finished`=1 and `busy`=0.
- **Delay command**: ROM {0x1280, 0xF003, 0x1101, 0xFFFF} with the macro defined → 12 cycles (3 ms × 4) of extra gap before the second send. Without the macro → three writes, the second being 0xF0/0x03.
- **Overflow**: ROM_AW=2, no end marker → four writes, then `rom_overflow`=1 and `config_finished`=1. A `resend` clears `rom_overflow` and restarts at PWR_WAIT.
- **Abort and restart**: `resend` during SEND is ignored, and the write completes. `rst` asserted while `i2c_send`=1 → `i2c_send`=0 on the next cycle and the state returns to IDLE.

Source files
------------

// File: rtl/ov7670_init_sequencer.sv
// ov7670_init_sequencer: OV7670 power-on sequencing and command-ROM loader; define OV7670_DELAY_CMD_EN for F0nn delay pseudo-commands
module ov7670_init_sequencer #(
  parameter int CLKS_PER_MS  = 50000,
  parameter int PWR_WAIT_MS  = 1,
  parameter int RST_PULSE_MS = 1,
  parameter int RST_WAIT_MS  = 10,
  parameter int ROM_AW       = 8,
  parameter int AUTO_START   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              resend,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [15:0]       rom_data,
  output logic              i2c_send,
  output logic [7:0]        i2c_register,
  output logic [7:0]        i2c_value,
  input  logic              i2c_taken,
  output logic              cam_pwdn,
  output logic              cam_reset_n,
  output logic              busy,
  output logic              config_finished,
  output logic              rom_overflow
);
  localparam int PW = CLKS_PER_MS > 1 ? $clog2(CLKS_PER_MS) : 1;
  typedef enum logic [3:0] {
    IDLE, PWR_WAIT, RST_PULSE, RST_WAIT, FETCH, DECODE, SEND,
`ifdef OV7670_DELAY_CMD_EN
    DELAY,
`endif
    DONE
  } state_t;
  state_t state, state_n;
  logic [PW-1:0] pre;
  logic [7:0] ms, ms_len, reg_n, val_n;
  logic [ROM_AW-1:0] addr_n;
  logic auto_go, tick_done, adv, ovf_n;
`ifdef OV7670_DELAY_CMD_EN
  logic [7:0] dly, dly_n;
`endif
  assign ms_len = state == PWR_WAIT  ? 8'(PWR_WAIT_MS) :
                  state == RST_PULSE ? 8'(RST_PULSE_MS) :
                  state == RST_WAIT  ? 8'(RST_WAIT_MS) :
`ifdef OV7670_DELAY_CMD_EN
                  state == DELAY     ? dly :
`endif
                  8'd0;
  // a zero-length interval completes on its first cycle
  assign tick_done = ms_len == 8'd0 || (ms == ms_len - 8'd1 && pre == PW'(CLKS_PER_MS - 1));
  always_comb begin
    state_n = state;
    addr_n = rom_addr;
    reg_n = i2c_register;
    val_n = i2c_value;
    ovf_n = rom_overflow;
    adv = 1'b0;
`ifdef OV7670_DELAY_CMD_EN
    dly_n = dly;
`endif
    case (state)
      IDLE:      if (resend || auto_go) state_n = PWR_WAIT;
      PWR_WAIT:  if (tick_done) state_n = RST_PULSE;
      RST_PULSE: if (tick_done) state_n = RST_WAIT;
      RST_WAIT: begin
        if (tick_done) begin
          state_n = FETCH;
          addr_n = '0;
        end
      end
      FETCH:     state_n = DECODE;
      DECODE: begin
        if (rom_data == 16'hFFFF) state_n = DONE;
`ifdef OV7670_DELAY_CMD_EN
        else if (rom_data[15:8] == 8'hF0) begin
          adv = rom_data[7:0] == 8'd0;
          state_n = adv ? state : DELAY;
          dly_n = rom_data[7:0];
        end
`endif
        else begin
          state_n = SEND;
          reg_n = rom_data[15:8];
          val_n = rom_data[7:0];
        end
      end
      SEND:      adv = i2c_taken;
`ifdef OV7670_DELAY_CMD_EN
      DELAY:     adv = tick_done;
`endif
      DONE: begin
        if (resend) begin
          state_n = PWR_WAIT;
          ovf_n = 1'b0;
        end
      end
      default:   state_n = IDLE;
    endcase
    if (adv) begin
      state_n = &rom_addr ? DONE : FETCH;
      ovf_n = rom_overflow | (&rom_addr);
      addr_n = &rom_addr ? rom_addr : rom_addr + 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (rst || state_n != state) begin
      pre <= '0;
      ms <= '0;
    end else if (pre == PW'(CLKS_PER_MS - 1)) begin
      pre <= '0;
      ms <= ms + 8'd1;
    end else begin
      pre <= pre + 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      auto_go <= AUTO_START != 0;
      rom_addr <= '0;
      i2c_send <= 1'b0;
      i2c_register <= 8'd0;
      i2c_value <= 8'd0;
      cam_pwdn <= 1'b1;
      cam_reset_n <= 1'b0;
      busy <= 1'b0;
      config_finished <= 1'b0;
      rom_overflow <= 1'b0;
    end else begin
      state <= state_n;
      auto_go <= 1'b0;
      rom_addr <= addr_n;
      i2c_send <= state_n == SEND;
      i2c_register <= reg_n;
      i2c_value <= val_n;
      cam_pwdn <= state_n == IDLE || state_n == PWR_WAIT;
      cam_reset_n <= !(state_n == IDLE || state_n == PWR_WAIT || state_n == RST_PULSE);
      busy <= !(state_n == IDLE || state_n == DONE);
      config_finished <= state_n == DONE;
      rom_overflow <= ovf_n;
    end
  end
`ifdef OV7670_DELAY_CMD_EN
  always_ff @(posedge clk) dly <= rst ? 8'd0 : dly_n;
`endif
endmodule
